// File: rtl/sensor_accum_param.sv
// Debounced pushbutton steps an accumulator by the index of the highest active sensor,
// with wrap/saturate overflow handling, a sticky range flag and a hysteresis motor FSM.
module sensor_accum_param #(
    parameter int N_SENS   = 8,
    parameter int ACC_W    = 4,
    parameter int DEB_CYC  = 4,
    parameter int SAT_MODE = 0,
    parameter int THR_ON   = 8,
    parameter int THR_OFF  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      sub,
    input  logic [N_SENS-1:0]         sensores,
    output logic [$clog2(N_SENS)-1:0] cod_out,
    output logic                      valid_out,
    output logic [ACC_W-1:0]          acc_out,
    output logic                      range_err,
    output logic [6:0]                segmentos,
    output logic [3:0]                leds,
    output logic                      motor_on
);

    localparam int CW  = $clog2(N_SENS);
    localparam int DCW = $clog2(DEB_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    logic           s1_q, s2_q;
    logic           deb_q, deb_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic           step;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic           err_q, err_d;
    state_t         state_q, state_d;
    logic [CW-1:0]  cod;
    logic [3:0]     nib;

    // Returns {overflow, result}; overflow is carry-out on add or borrow on subtract.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc,
                                                 input logic [ACC_W-1:0] delta,
                                                 input logic             do_sub);
        logic [ACC_W:0]   ext;
        logic [ACC_W-1:0] res;
        if (do_sub) ext = {1'b0, acc} - {1'b0, delta};
        else        ext = {1'b0, acc} + {1'b0, delta};
        res = ext[ACC_W-1:0];
        if (ext[ACC_W] && (SAT_MODE != 0)) res = do_sub ? '0 : '1;
        return {ext[ACC_W], res};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
            4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
            4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
            4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    always_comb begin
        cod = '0;
        for (int i = 0; i < N_SENS; i++) begin
            if (sensores[i]) cod = CW'(i);
        end
    end

    assign cod_out   = cod;
    assign valid_out = |sensores;

    // Step fires on the same edge the debounced level rises.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        step  = 1'b0;
        if (s2_q != deb_q) begin
            if (cnt_q == DCW'(DEB_CYC - 1)) begin
                deb_d = s2_q;
                step  = s2_q;
            end else begin
                cnt_d = cnt_q + DCW'(1);
            end
        end
    end

    always_comb begin
        logic [ACC_W:0] nxt;
        acc_d = acc_q;
        err_d = err_q;
        nxt   = acc_step(acc_q, ACC_W'(cod), sub);
        if (clear) begin
            acc_d = '0;
            err_d = 1'b0;
        end else if (step && valid_out) begin
            acc_d = nxt[ACC_W-1:0];
            err_d = err_q | nxt[ACC_W];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc_q >= ACC_W'(THR_ON))  state_d = RUN;
            RUN:     if (acc_q <= ACC_W'(THR_OFF)) state_d = IDLE;
            default: state_d = FAULT;
        endcase
        if (err_q) state_d = FAULT;
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            state_q <= IDLE;
        end else begin
            s1_q    <= enable;
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign acc_out   = acc_q;
    assign range_err = err_q;
    assign motor_on  = (state_q == RUN);

    generate
        if (ACC_W >= 4) begin : g_nib_full
            assign nib = acc_q[3:0];
        end else begin : g_nib_ext
            assign nib = 4'(acc_q);
        end
        for (genvar i = 0; i < 4; i++) begin : g_led
            if (i < ACC_W) begin : g_on
                assign leds[i] = acc_q[i];
            end else begin : g_off
                assign leds[i] = 1'b0;
            end
        end
    endgenerate

    assign segmentos = seg7(nib);

endmodule

// File: tb/tb_sensor_accum_param.sv
// Bench for sensor_accum_param: wrap and saturate instances share stimulus and are
// compared each cycle against a sliding-window debounce / integer accumulator model.
module tb_sensor_accum_param;

    localparam int N_SENS  = 8;
    localparam int ACC_W   = 4;
    localparam int DEB_CYC = 4;
    localparam int THR_ON  = 8;
    localparam int THR_OFF = 3;
    localparam int CW      = 3;
    localparam int MAXV    = 15;

    logic clk = 1'b0;
    logic reset, enable, clear, sub;
    logic [N_SENS-1:0] sensores;

    logic [CW-1:0]    cod0, cod1;
    logic             valid0, valid1, err0, err1, mot0, mot1;
    logic [ACC_W-1:0] acc0, acc1;
    logic [6:0]       seg0, seg1;
    logic [3:0]       led0, led1;

    always #5 clk = ~clk;

    sensor_accum_param #(.N_SENS(N_SENS), .ACC_W(ACC_W), .DEB_CYC(DEB_CYC), .SAT_MODE(0),
                         .THR_ON(THR_ON), .THR_OFF(THR_OFF)) u_wrap (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .sub(sub),
        .sensores(sensores), .cod_out(cod0), .valid_out(valid0), .acc_out(acc0),
        .range_err(err0), .segmentos(seg0), .leds(led0), .motor_on(mot0));

    sensor_accum_param #(.N_SENS(N_SENS), .ACC_W(ACC_W), .DEB_CYC(DEB_CYC), .SAT_MODE(1),
                         .THR_ON(THR_ON), .THR_OFF(THR_OFF)) u_sat (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .sub(sub),
        .sensores(sensores), .cod_out(cod1), .valid_out(valid1), .acc_out(acc1),
        .range_err(err1), .segmentos(seg1), .leds(led1), .motor_on(mot1));

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: index 0 = wrap instance, 1 = saturate instance. FSM: 0 idle, 1 run, 2 fault.
    int acc_m [2];
    int st_m  [2];
    bit err_m [2];
    bit deb_m;
    int k_m, last_chg;
    bit hist [$];
    logic [6:0] seg_lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            acc_m[m] = 0; st_m[m] = 0; err_m[m] = 0;
        end
        deb_m = 0; k_m = 0; last_chg = 0;
        hist.delete();
    endfunction

    // Debounced level follows the synchronized input when it has disagreed with it on the
    // last DEB_CYC edges, all after the previous change; synchronized input lags by two edges.
    function automatic void model_edge();
        bit ok, rise, s2;
        int c, a;
        k_m++;
        hist.push_back(enable);
        ok = (k_m - DEB_CYC >= last_chg);
        for (int j = 0; j < DEB_CYC; j++) begin
            s2 = (k_m - j >= 3) ? hist[k_m - j - 3] : 1'b0;
            if (s2 == deb_m) ok = 0;
        end
        rise = 0;
        if (ok) begin
            deb_m = !deb_m;
            last_chg = k_m;
            rise = deb_m;
        end
        c = $clog2(int'(sensores) + 1) - 1;
        for (int m = 0; m < 2; m++) begin
            int nst;
            nst = st_m[m];
            if (st_m[m] == 0 && acc_m[m] >= THR_ON)  nst = 1;
            if (st_m[m] == 1 && acc_m[m] <= THR_OFF) nst = 0;
            if (err_m[m]) nst = 2;
            if (clear) nst = 0;
            if (clear) begin
                acc_m[m] = 0; err_m[m] = 0;
            end else if (rise && sensores != 0) begin
                a = sub ? acc_m[m] - c : acc_m[m] + c;
                if (a < 0 || a > MAXV) begin
                    err_m[m] = 1;
                    if (m == 1) a = (a < 0) ? 0 : MAXV;
                    else        a = ((a % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
                end
                acc_m[m] = a;
            end
            st_m[m] = nst;
        end
    endfunction

    task automatic check_all(input string tag);
        int hi;
        hi = (sensores == 0) ? 0 : $clog2(int'(sensores) + 1) - 1;
        for (int m = 0; m < 2; m++) begin
            check({tag, "/acc"},   (m == 0) ? acc0 : acc1, acc_m[m]);
            check({tag, "/err"},   (m == 0) ? err0 : err1, err_m[m]);
            check({tag, "/motor"}, (m == 0) ? mot0 : mot1, st_m[m] == 1);
            check({tag, "/cod"},   (m == 0) ? cod0 : cod1, hi);
            check({tag, "/valid"}, (m == 0) ? valid0 : valid1, sensores != 0);
            check({tag, "/leds"},  (m == 0) ? led0 : led1, acc_m[m] & 15);
            check({tag, "/seg"},   (m == 0) ? seg0 : seg1, ~seg_lit[acc_m[m] & 15] & 7'h7F);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    // Called just after an edge; the pulse sits entirely between edges.
    task automatic do_reset();
        #2 reset = 1'b1;
        #2;
        check("rst_acc0", acc0, 0);   check("rst_acc1", acc1, 0);
        check("rst_err0", err0, 0);   check("rst_err1", err1, 0);
        check("rst_mot0", mot0, 0);   check("rst_mot1", mot1, 0);
        check("rst_leds", led0, 0);   check("rst_seg", seg0, 7'b1000000);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic press(input logic [N_SENS-1:0] s, input logic sb);
        sensores = s; sub = sb; enable = 1'b1;
        repeat (DEB_CYC + 4) cycle();
        enable = 1'b0;
        repeat (DEB_CYC + 4) cycle();
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; clear = 1'b0; sub = 1'b0; sensores = '0;
        model_reset();
        @(posedge clk); #1;
        do_reset();
        check_all("idle");

        // Hold with sensors 0000_0101: single +2 step on the sixth edge.
        sensores = 8'b0000_0101; enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 1) check("cod_is_2", cod0, 2);
            if (i == 5) check("no_step_edge5", acc0, 0);
            if (i == 6) check("step_edge6", acc0, 2);
        end
        enable = 1'b0;
        repeat (DEB_CYC + 4) cycle();
        check("held_one_step", acc0, 2);

        // Bounce shorter than the debounce window.
        enable = 1'b1; repeat (3) cycle();
        enable = 1'b0; repeat (2) cycle();
        enable = 1'b1; repeat (3) cycle();
        enable = 1'b0; repeat (DEB_CYC + 4) cycle();
        check("bounce_no_step", acc0, 2);

        // Climb to 14 then overflow by 3.
        press(8'h80, 1'b0);
        press(8'h20, 1'b0);
        check("acc_14", acc0, 14);
        press(8'h08, 1'b0);
        check("wrap_acc", acc0, 1);      check("wrap_err", err0, 1);
        check("sat_acc", acc1, 15);      check("sat_err", err1, 1);
        check("fault_mot0", mot0, 0);    check("fault_mot1", mot1, 0);

        clear = 1'b1; cycle(); clear = 1'b0;
        check("clr_acc", acc0, 0);       check("clr_err", err0, 0);

        // Hysteresis: 7, 9 (run), 4 (run), 3 (idle).
        press(8'h80, 1'b0);
        press(8'h04, 1'b0);
        check("run_at_9", mot0, 1);
        press(8'h20, 1'b1);
        check("acc_4", acc0, 4);         check("run_at_4", mot0, 1);
        press(8'h02, 1'b1);
        check("acc_3", acc0, 3);         check("idle_at_3", mot0, 0);

        // Clear on the step edge with acc=5.
        clear = 1'b1; cycle(); clear = 1'b0;
        press(8'h20, 1'b0);
        check("acc_5", acc0, 5);
        enable = 1'b1;
        repeat (DEB_CYC + 1) cycle();
        clear = 1'b1; cycle(); clear = 1'b0;
        check("clr_beats_step_acc", acc0, 0);
        check("clr_beats_step_err", err0, 0);
        enable = 1'b0;
        repeat (DEB_CYC + 4) cycle();
        check("clr_no_late_step", acc0, 0);

        // Reset mid-debounce with enable held.
        sensores = 8'h10; enable = 1'b1;
        repeat (3) cycle();
        do_reset();
        for (int i = 1; i <= DEB_CYC + 2; i++) begin
            cycle();
            if (i == DEB_CYC + 1) check("rst_no_early", acc0, 0);
            if (i == DEB_CYC + 2) check("rst_fresh_step", acc0, 4);
        end
        enable = 1'b0;
        repeat (DEB_CYC + 4) cycle();

        // Random bursts of varying length, sensor pattern, direction and occasional clear.
        for (int b = 0; b < 60; b++) begin
            sensores = (b % 5 == 4) ? '0 : N_SENS'($urandom_range(0, 255));
            sub = 1'($urandom_range(0, 1));
            enable = 1'b1;
            repeat ($urandom_range(1, 12)) begin
                clear = ($urandom_range(0, 29) == 0);
                cycle();
            end
            clear = 1'b0;
            enable = 1'b0;
            repeat ($urandom_range(1, 10)) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
